// File: rtl/rst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer_pkg
// Description : Shared definitions for the staged reset-release controller.
//               Holds the state encoding and a ceil-log2 helper used to size
//               the internal counter and the stage-index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_sequencer_pkg;

    // State encoding, 2 bits wide
    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    // Smallest r such that 2**r >= value (clog2(1) = 0)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : rst_sequencer_pkg
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Staged reset-release controller. Holds NUM_STAGES reset
//               outputs asserted and releases them one at a time in index
//               order. Each release is preceded by a HOLD_CYCLES gap and
//               followed by a wait for that stage's ack, bounded by
//               TIMEOUT_CYCLES. A single counter serves both the hold gap and
//               the ack timeout.
// Ports       : clk          - clock
//               rst          - synchronous active-high reset
//               sw_rst_req   - one-cycle request to restart the sequence
//               stage_ack    - per-stage ready/ack level inputs
//               stage_rst    - per-stage active-high resets (registered)
//               all_done     - every stage released and acked/timed out
//               busy         - sequencing in progress (HOLD or WAIT_ACK)
//               cur_stage    - stage currently held or waited on
//               timeout_err  - sticky: some stage never acked in time
//               err_stage    - first stage that timed out
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = clog2(max2(HOLD_CYCLES, TIMEOUT_CYCLES) + 1),
    parameter int SW             = max2(1, clog2(NUM_STAGES))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_done,
    output logic                  busy,
    output logic [SW-1:0]         cur_stage,
    output logic                  timeout_err,
    output logic [SW-1:0]         err_stage
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0]    C_LAST_STAGE = SW'(NUM_STAGES - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SW-1:0]         w_stage_nxt;
    logic                  w_release;
    logic                  w_timeout;
    logic                  w_advance;
    logic                  w_cur_ack;

    logic [NUM_STAGES-1:0] w_stage_rst_nxt;
    logic                  w_all_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_terr_nxt;
    logic [SW-1:0]         w_err_stage_nxt;

    // Ack of the stage being waited on; other stages' acks are ignored
    always_comb begin
        w_cur_ack = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (cur_stage == SW'(i)) begin
                w_cur_ack = stage_ack[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register (all outputs are registered here too)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            cur_stage   <= '0;
            stage_rst   <= '1;
            all_done    <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            err_stage   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            cur_stage   <= w_stage_nxt;
            stage_rst   <= w_stage_rst_nxt;
            all_done    <= w_all_done_nxt;
            busy        <= w_busy_nxt;
            timeout_err <= w_terr_nxt;
            err_stage   <= w_err_stage_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A software restart overrides any progression that
    // would otherwise happen in the same cycle (ack, timeout, hold expiry).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = cur_stage;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;

        if (sw_rst_req) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        w_release   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT_ACK;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_cur_ack) begin
                        w_advance = 1'b1;
                    end else if (r_cnt == C_TO_LAST) begin
                        // A timed-out stage is treated as acked so the rest
                        // of the system still comes out of reset.
                        w_timeout = 1'b1;
                        w_advance = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end

                    if (w_advance) begin
                        w_cnt_nxt = '0;
                        if (cur_stage == C_LAST_STAGE) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_stage_nxt = cur_stage + SW'(1);
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    // Unreachable encoding: restart the sequence
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        w_stage_rst_nxt = stage_rst;
        if (sw_rst_req || (r_state != ST_HOLD && r_state != ST_WAIT_ACK
                           && r_state != ST_DONE)) begin
            w_stage_rst_nxt = '1;
        end else if (w_release) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (cur_stage == SW'(i)) begin
                    w_stage_rst_nxt[i] = 1'b0;
                end
            end
        end

        w_all_done_nxt  = (w_state_nxt == ST_DONE);
        w_busy_nxt      = (w_state_nxt != ST_DONE);

        // Only the first timeout since rst records its stage
        w_terr_nxt      = timeout_err | w_timeout;
        w_err_stage_nxt = err_stage;
        if (w_timeout && !timeout_err) begin
            w_err_stage_nxt = cur_stage;
        end
    end

endmodule : rst_sequencer
`default_nettype wire
